// File: rtl/ibex_pkg.sv
// Shared types for the ID-stage multi-cycle sequencer.
package ibex_pkg;

  typedef enum logic [0:0] {
    FIRST_CYCLE,
    MULTI_CYCLE
  } id_fsm_e;

  typedef enum logic [2:0] {
    MC_NONE,
    MC_JUMP,
    MC_BRANCH,
    MC_LSU,
    MC_MD
  } mc_kind_e;

endpackage

// File: rtl/ibex_stall_counter.sv
// Saturating 32-bit event counter, used for ID stall-cycle accounting.
module ibex_stall_counter (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        en_i,
  output logic [31:0] cnt_o
);

  logic [31:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en_i && (cnt_q != 32'hFFFF_FFFF)) begin
      cnt_d = cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/ibex_id_multicycle_seq.sv
// ID-stage sequencer for multi-cycle instructions (jump, branch, LSU, mult/div).
// Optional stall-cycle counter is enabled by defining IBEX_ID_STALL_PERF_EN.
module ibex_id_multicycle_seq
  import ibex_pkg::*;
#(
  parameter bit RV32M             = 1'b1,
  parameter bit BRANCH_TARGET_ALU = 1'b0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        instr_valid_i,
  input  logic        halt_id_i,
  input  logic        flush_i,
  input  logic        illegal_insn_i,
  input  logic        jump_in_dec_i,
  input  logic        branch_in_dec_i,
  input  logic        data_req_dec_i,
  input  logic        mult_en_dec_i,
  input  logic        div_en_dec_i,
  input  logic        branch_decision_i,
  input  logic        lsu_resp_valid_i,
  input  logic        multdiv_ready_i,
  output logic        instr_new_o,
  output logic        lsu_req_o,
  output logic        multdiv_en_o,
  output logic        multdiv_kill_o,
  output logic        branch_set_o,
  output logic        jump_set_o,
  output logic        id_ready_o,
  output logic        stall_o,
  output logic [31:0] perf_stall_cnt_o
);

  id_fsm_e  state_q, state_d;
  mc_kind_e mc_kind_q, mc_kind_d;
  logic     lsu_outstanding_q, lsu_outstanding_d;

  logic go, legal, md_op, lsu_busy;

  assign go    = instr_valid_i & ~halt_id_i & ~flush_i;
  assign legal = go & ~illegal_insn_i;
  assign md_op = RV32M & (mult_en_dec_i | div_en_dec_i);

  // A response in this cycle frees the LSU before a new request is considered,
  // and also retires any stale response left behind by a flushed access.
  assign lsu_busy = lsu_outstanding_q & ~lsu_resp_valid_i;

  always_comb begin
    state_d           = state_q;
    mc_kind_d         = mc_kind_q;
    lsu_outstanding_d = lsu_busy;
    instr_new_o       = 1'b0;
    lsu_req_o         = 1'b0;
    multdiv_en_o      = 1'b0;
    multdiv_kill_o    = 1'b0;
    branch_set_o      = 1'b0;
    jump_set_o        = 1'b0;
    id_ready_o        = 1'b0;

    if (!rst_i) begin
      if ((state_q == MULTI_CYCLE) && flush_i) begin
        state_d        = FIRST_CYCLE;
        mc_kind_d      = MC_NONE;
        multdiv_kill_o = instr_valid_i & (mc_kind_q == MC_MD);
      end else if (instr_valid_i) begin
        unique case (state_q)
          FIRST_CYCLE: begin
            instr_new_o = go;
            if (legal) begin
              if (data_req_dec_i) begin
                if (!lsu_busy) begin
                  lsu_req_o         = 1'b1;
                  lsu_outstanding_d = 1'b1;
                  mc_kind_d         = MC_LSU;
                  state_d           = MULTI_CYCLE;
                end
              end else if (md_op) begin
                multdiv_en_o = 1'b1;
                if (multdiv_ready_i) begin
                  id_ready_o = 1'b1;
                end else begin
                  mc_kind_d = MC_MD;
                  state_d   = MULTI_CYCLE;
                end
              end else if (jump_in_dec_i) begin
                jump_set_o = 1'b1;
                mc_kind_d  = MC_JUMP;
                state_d    = MULTI_CYCLE;
              end else if (branch_in_dec_i && branch_decision_i) begin
                if (BRANCH_TARGET_ALU) begin
                  branch_set_o = 1'b1;
                  id_ready_o   = 1'b1;
                end else begin
                  mc_kind_d = MC_BRANCH;
                  state_d   = MULTI_CYCLE;
                end
              end else begin
                id_ready_o = 1'b1;
              end
            end else if (go) begin
              id_ready_o = 1'b1;
            end
          end

          MULTI_CYCLE: begin
            // halt_id_i is deliberately ignored here: started operations complete.
            unique case (mc_kind_q)
              MC_JUMP: begin
                id_ready_o = 1'b1;
                mc_kind_d  = MC_NONE;
                state_d    = FIRST_CYCLE;
              end
              MC_BRANCH: begin
                branch_set_o = 1'b1;
                id_ready_o   = 1'b1;
                mc_kind_d    = MC_NONE;
                state_d      = FIRST_CYCLE;
              end
              MC_LSU: begin
                if (lsu_resp_valid_i) begin
                  id_ready_o = 1'b1;
                  mc_kind_d  = MC_NONE;
                  state_d    = FIRST_CYCLE;
                end
              end
              MC_MD: begin
                multdiv_en_o = 1'b1;
                if (multdiv_ready_i) begin
                  id_ready_o = 1'b1;
                  mc_kind_d  = MC_NONE;
                  state_d    = FIRST_CYCLE;
                end
              end
              default: begin
                mc_kind_d = MC_NONE;
                state_d   = FIRST_CYCLE;
              end
            endcase
          end

          default: state_d = FIRST_CYCLE;
        endcase
      end
    end
  end

  assign stall_o = ~rst_i & instr_valid_i & ~id_ready_o & ~flush_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q           <= FIRST_CYCLE;
      mc_kind_q         <= MC_NONE;
      lsu_outstanding_q <= 1'b0;
    end else begin
      state_q           <= state_d;
      mc_kind_q         <= mc_kind_d;
      lsu_outstanding_q <= lsu_outstanding_d;
    end
  end

`ifdef IBEX_ID_STALL_PERF_EN
  ibex_stall_counter u_stall_counter (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .en_i  (stall_o),
    .cnt_o (perf_stall_cnt_o)
  );
`else
  assign perf_stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_ibex_id_multicycle_seq.sv
// Directed bench for ibex_id_multicycle_seq (default parameters).
module tb_ibex_id_multicycle_seq;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        instr_valid_i, halt_id_i, flush_i, illegal_insn_i;
  logic        jump_in_dec_i, branch_in_dec_i, data_req_dec_i;
  logic        mult_en_dec_i, div_en_dec_i, branch_decision_i;
  logic        lsu_resp_valid_i, multdiv_ready_i;
  logic        instr_new_o, lsu_req_o, multdiv_en_o, multdiv_kill_o;
  logic        branch_set_o, jump_set_o, id_ready_o, stall_o;
  logic [31:0] perf_stall_cnt_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_i = ~clk_i;

  ibex_id_multicycle_seq dut (
    .clk_i             (clk_i),
    .rst_i             (rst_i),
    .instr_valid_i     (instr_valid_i),
    .halt_id_i         (halt_id_i),
    .flush_i           (flush_i),
    .illegal_insn_i    (illegal_insn_i),
    .jump_in_dec_i     (jump_in_dec_i),
    .branch_in_dec_i   (branch_in_dec_i),
    .data_req_dec_i    (data_req_dec_i),
    .mult_en_dec_i     (mult_en_dec_i),
    .div_en_dec_i      (div_en_dec_i),
    .branch_decision_i (branch_decision_i),
    .lsu_resp_valid_i  (lsu_resp_valid_i),
    .multdiv_ready_i   (multdiv_ready_i),
    .instr_new_o       (instr_new_o),
    .lsu_req_o         (lsu_req_o),
    .multdiv_en_o      (multdiv_en_o),
    .multdiv_kill_o    (multdiv_kill_o),
    .branch_set_o      (branch_set_o),
    .jump_set_o        (jump_set_o),
    .id_ready_o        (id_ready_o),
    .stall_o           (stall_o),
    .perf_stall_cnt_o  (perf_stall_cnt_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Compact check of the single-bit outputs: {instr_new, id_ready, stall}.
  task automatic chk3(input string tag, input logic [2:0] exp);
    chk(tag, {29'd0, instr_new_o, id_ready_o, stall_o}, {29'd0, exp});
  endtask

  task automatic clr();
    instr_valid_i = 1'b0; halt_id_i = 1'b0; flush_i = 1'b0; illegal_insn_i = 1'b0;
    jump_in_dec_i = 1'b0; branch_in_dec_i = 1'b0; data_req_dec_i = 1'b0;
    mult_en_dec_i = 1'b0; div_en_dec_i = 1'b0; branch_decision_i = 1'b0;
    lsu_resp_valid_i = 1'b0; multdiv_ready_i = 1'b0;
  endtask

  task automatic next_cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic sample();
    @(negedge clk_i);
  endtask

  initial begin
    clr();
    rst_i = 1'b1;
    instr_valid_i = 1'b1;
    sample();
    chk3("reset_outs", 3'b000);
    chk("reset_perf", perf_stall_cnt_o, 32'd0);

    // ADD retires in one cycle
    next_cyc(); rst_i = 1'b0; clr(); instr_valid_i = 1'b1;
    sample(); chk3("add", 3'b110);

    next_cyc(); clr();
    sample(); chk3("idle", 3'b000);

    // JAL: set in cycle 0, retire in cycle 1
    next_cyc(); clr(); instr_valid_i = 1'b1; jump_in_dec_i = 1'b1;
    sample(); chk3("jal_c0", 3'b101); chk("jal_c0_set", {31'd0, jump_set_o}, 32'd1);
    next_cyc();
    sample(); chk3("jal_c1", 3'b010); chk("jal_c1_set", {31'd0, jump_set_o}, 32'd0);

    // BEQ taken, target computed in cycle 1
    next_cyc(); clr(); instr_valid_i = 1'b1; branch_in_dec_i = 1'b1; branch_decision_i = 1'b1;
    sample(); chk3("beq_t_c0", 3'b101); chk("beq_t_c0_set", {31'd0, branch_set_o}, 32'd0);
    next_cyc();
    sample(); chk3("beq_t_c1", 3'b010); chk("beq_t_c1_set", {31'd0, branch_set_o}, 32'd1);

    // BEQ not taken
    next_cyc(); branch_decision_i = 1'b0;
    sample(); chk3("beq_nt", 3'b110); chk("beq_nt_set", {31'd0, branch_set_o}, 32'd0);

    // Illegal load: retires without a request
    next_cyc(); clr(); instr_valid_i = 1'b1; illegal_insn_i = 1'b1; data_req_dec_i = 1'b1;
    sample(); chk3("illegal", 3'b110); chk("illegal_req", {31'd0, lsu_req_o}, 32'd0);

    // Halt in FIRST_CYCLE holds the instruction
    next_cyc(); clr(); instr_valid_i = 1'b1; halt_id_i = 1'b1;
    sample(); chk3("halt_first", 3'b001);

    // Fresh reset so the LW stall count starts from zero
    next_cyc(); clr(); rst_i = 1'b1;
    #2 rst_i = 1'b0;
    next_cyc(); instr_valid_i = 1'b1; data_req_dec_i = 1'b1;
    sample(); chk3("lw_c0", 3'b101); chk("lw_c0_req", {31'd0, lsu_req_o}, 32'd1);
    next_cyc();
    sample(); chk3("lw_c1", 3'b001); chk("lw_c1_req", {31'd0, lsu_req_o}, 32'd0);
    next_cyc();
    sample(); chk3("lw_c2", 3'b001);
    next_cyc(); lsu_resp_valid_i = 1'b1;
    sample(); chk3("lw_c3", 3'b010); chk("lw_c3_req", {31'd0, lsu_req_o}, 32'd0);
`ifdef IBEX_ID_STALL_PERF_EN
    chk("lw_perf", perf_stall_cnt_o, 32'd3);
`else
    chk("lw_perf", perf_stall_cnt_o, 32'd0);
`endif

    // MUL with result ready in its first cycle
    next_cyc(); clr(); instr_valid_i = 1'b1; mult_en_dec_i = 1'b1; multdiv_ready_i = 1'b1;
    sample(); chk3("mul_fast", 3'b110); chk("mul_fast_en", {31'd0, multdiv_en_o}, 32'd1);

    // MUL in MULTI_CYCLE is not interrupted by halt
    next_cyc(); multdiv_ready_i = 1'b0;
    sample(); chk3("mul_c0", 3'b101);
    next_cyc(); halt_id_i = 1'b1; multdiv_ready_i = 1'b1;
    sample(); chk3("mul_halt_c1", 3'b010); chk("mul_c1_en", {31'd0, multdiv_en_o}, 32'd1);

    // DIV flushed in cycle 2
    next_cyc(); clr(); instr_valid_i = 1'b1; div_en_dec_i = 1'b1;
    sample(); chk3("div_c0", 3'b101); chk("div_c0_en", {31'd0, multdiv_en_o}, 32'd1);
    next_cyc();
    sample(); chk3("div_c1", 3'b001); chk("div_c1_kill", {31'd0, multdiv_kill_o}, 32'd0);
    next_cyc(); flush_i = 1'b1;
    sample(); chk3("div_c2", 3'b000); chk("div_c2_kill", {31'd0, multdiv_kill_o}, 32'd1);
    next_cyc(); clr(); instr_valid_i = 1'b1;
    sample(); chk3("div_c3_first", 3'b110); chk("div_c3_kill", {31'd0, multdiv_kill_o}, 32'd0);

    // SW flushed, next SW waits for the stale response
    next_cyc(); clr(); instr_valid_i = 1'b1; data_req_dec_i = 1'b1;
    sample(); chk("sw0_req", {31'd0, lsu_req_o}, 32'd1);
    next_cyc(); flush_i = 1'b1;
    sample(); chk3("sw_flush", 3'b000); chk("sw_flush_req", {31'd0, lsu_req_o}, 32'd0);
    next_cyc(); flush_i = 1'b0;
    sample(); chk3("sw1_c2", 3'b101); chk("sw1_c2_req", {31'd0, lsu_req_o}, 32'd0);
    next_cyc();
    sample(); chk3("sw1_c3", 3'b101); chk("sw1_c3_req", {31'd0, lsu_req_o}, 32'd0);
    next_cyc(); lsu_resp_valid_i = 1'b1;
    sample(); chk3("sw1_c4", 3'b101); chk("sw1_c4_req", {31'd0, lsu_req_o}, 32'd1);
    next_cyc(); lsu_resp_valid_i = 1'b0;
    sample(); chk3("sw1_c5", 3'b001); chk("sw1_c5_req", {31'd0, lsu_req_o}, 32'd0);
    next_cyc(); lsu_resp_valid_i = 1'b1;
    sample(); chk3("sw1_c6", 3'b010);

    // Stray response with nothing outstanding is ignored
    next_cyc(); clr(); lsu_resp_valid_i = 1'b1;
    sample(); chk3("stray_resp", 3'b000);
    next_cyc(); clr(); instr_valid_i = 1'b1; data_req_dec_i = 1'b1;
    sample(); chk("lw_after_stray_req", {31'd0, lsu_req_o}, 32'd1);
    next_cyc(); lsu_resp_valid_i = 1'b1;
    sample(); chk3("lw_after_stray_done", 3'b010);

    // Reset mid-DIV: no kill pulse, state back to FIRST_CYCLE
    next_cyc(); clr(); instr_valid_i = 1'b1; div_en_dec_i = 1'b1;
    sample(); chk3("div_rst_c0", 3'b101);
    next_cyc(); rst_i = 1'b1;
    sample(); chk3("div_rst_c1", 3'b000);
    chk("div_rst_kill", {30'd0, multdiv_kill_o, multdiv_en_o}, 32'd0);
    next_cyc(); rst_i = 1'b0;
    sample(); chk3("div_rst_c2_first", 3'b101);

    next_cyc(); clr();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
